// File: rtl/axis_stream_monitor.sv
// Passive AXI4-Stream tap: captures beats into a FIFO, tracks packet beat/byte
// counts and framing errors. Define AXIS_MON_PROTOCOL_CHECK_EN for stall-stability checks.
module axis_stream_monitor #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int HAS_TREADY = 1
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    TVALID,
  input  logic                    TREADY,
  input  logic [DATA_WIDTH-1:0]   TDATA,
  input  logic [DATA_WIDTH/8-1:0] TSTRB,
  input  logic [DATA_WIDTH/8-1:0] TKEEP,
  input  logic                    TLAST,
  input  logic [ID_WIDTH-1:0]     TID,
  input  logic [DEST_WIDTH-1:0]   TDEST,
  input  logic [USER_WIDTH-1:0]   TUSER,
  output logic                    cap_valid,
  input  logic                    cap_ready,
  output logic [DATA_WIDTH-1:0]   cap_tdata,
  output logic [DATA_WIDTH/8-1:0] cap_tstrb,
  output logic [DATA_WIDTH/8-1:0] cap_tkeep,
  output logic                    cap_tlast,
  output logic [ID_WIDTH-1:0]     cap_tid,
  output logic [DEST_WIDTH-1:0]   cap_tdest,
  output logic [USER_WIDTH-1:0]   cap_tuser,
  output logic                    pkt_done,
  output logic [CNT_WIDTH-1:0]    pkt_beats,
  output logic [CNT_WIDTH-1:0]    pkt_bytes,
  output logic [CNT_WIDTH-1:0]    drop_cnt,
  output logic                    err_id_change,
  output logic                    err_unstable,
  output logic                    err_valid_drop,
  input  logic                    clear
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + 2 * KW + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, IN_PKT} state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [KW-1:0] k);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < KW; i++) c = c + CNT_WIDTH'(k[i]);
    return c;
  endfunction

  logic              beat, push, pop, full, drop;
  logic [EW-1:0]     bus_entry, head;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d, keep_cnt, beat_sum, byte_sum;

  assign beat      = TVALID && (TREADY || (HAS_TREADY == 0));
  assign bus_entry = {TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER};
  assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
  assign cap_valid = (count_q != '0);
  assign pop       = cap_valid && cap_ready;
  assign push      = beat && (!full || pop);
  assign drop      = beat && full && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear)                             drop_cnt_d = '0;
    else if (drop && drop_cnt_q != '1)     drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is not reset; outputs are gated by cap_valid so stale contents never leak.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr_q] <= bus_entry;
  end

  assign head = cap_valid ? mem[rd_ptr_q] : '0;
  assign {cap_tdata, cap_tstrb, cap_tkeep, cap_tlast, cap_tid, cap_tdest, cap_tuser} = head;
  assign drop_cnt = drop_cnt_q;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] beat_acc_q, beat_acc_d, byte_acc_q, byte_acc_d;
  logic [CNT_WIDTH-1:0] pkt_beats_q, pkt_beats_d, pkt_bytes_q, pkt_bytes_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                 done_q, done_d, id_err_set, err_id_q;

  assign keep_cnt = popcount(TKEEP);
  assign beat_sum = sat_add(beat_acc_q, CNT_WIDTH'(1));
  assign byte_sum = sat_add(byte_acc_q, keep_cnt);

  always_comb begin
    state_d     = state_q;
    beat_acc_d  = beat_acc_q;
    byte_acc_d  = byte_acc_q;
    id_d        = id_q;
    dest_d      = dest_q;
    done_d      = 1'b0;
    pkt_beats_d = pkt_beats_q;
    pkt_bytes_d = pkt_bytes_q;
    id_err_set  = 1'b0;
    case (state_q)
      IDLE: if (beat) begin
        if (TLAST) begin
          done_d      = 1'b1;
          pkt_beats_d = CNT_WIDTH'(1);
          pkt_bytes_d = keep_cnt;
        end else begin
          state_d    = IN_PKT;
          id_d       = TID;
          dest_d     = TDEST;
          beat_acc_d = CNT_WIDTH'(1);
          byte_acc_d = keep_cnt;
        end
      end
      IN_PKT: if (beat) begin
        id_err_set = (TID != id_q) || (TDEST != dest_q);
        beat_acc_d = beat_sum;
        byte_acc_d = byte_sum;
        if (TLAST) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          pkt_beats_d = beat_sum;
          pkt_bytes_d = byte_sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      beat_acc_q  <= '0;
      byte_acc_q  <= '0;
      id_q        <= '0;
      dest_q      <= '0;
      done_q      <= 1'b0;
      pkt_beats_q <= '0;
      pkt_bytes_q <= '0;
      err_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_acc_q  <= beat_acc_d;
      byte_acc_q  <= byte_acc_d;
      id_q        <= id_d;
      dest_q      <= dest_d;
      done_q      <= done_d;
      pkt_beats_q <= pkt_beats_d;
      pkt_bytes_q <= pkt_bytes_d;
      err_id_q    <= clear ? 1'b0 : (err_id_q | id_err_set);
    end
  end

  assign pkt_done      = done_q;
  assign pkt_beats     = pkt_beats_q;
  assign pkt_bytes     = pkt_bytes_q;
  assign err_id_change = err_id_q;

`ifdef AXIS_MON_PROTOCOL_CHECK_EN
  logic          stall_q, err_unstable_q, err_vdrop_q;
  logic [EW-1:0] snap_q;

  always_ff @(posedge ACLK) begin
    snap_q <= bus_entry;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      stall_q        <= 1'b0;
      err_unstable_q <= 1'b0;
      err_vdrop_q    <= 1'b0;
    end else begin
      stall_q        <= (HAS_TREADY != 0) && TVALID && !TREADY;
      err_unstable_q <= clear ? 1'b0 : (err_unstable_q | (stall_q && (bus_entry != snap_q)));
      err_vdrop_q    <= clear ? 1'b0 : (err_vdrop_q | (stall_q && !TVALID));
    end
  end

  assign err_unstable   = err_unstable_q;
  assign err_valid_drop = err_vdrop_q;
`else
  assign err_unstable   = 1'b0;
  assign err_valid_drop = 1'b0;
`endif
endmodule

// File: tb/tb_axis_stream_monitor.sv
// Directed self-checking bench for axis_stream_monitor (default parameters).
module tb_axis_stream_monitor;
  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        TVALID, TREADY, TLAST;
  logic [31:0] TDATA;
  logic [3:0]  TSTRB, TKEEP, TID, TDEST;
  logic [0:0]  TUSER;
  logic        cap_valid, cap_ready, cap_tlast;
  logic [31:0] cap_tdata;
  logic [3:0]  cap_tstrb, cap_tkeep, cap_tid, cap_tdest;
  logic [0:0]  cap_tuser;
  logic        pkt_done, err_id_change, err_unstable, err_valid_drop, clear;
  logic [15:0] pkt_beats, pkt_bytes, drop_cnt;

  int checks   = 0;
  int failures = 0;

`ifdef AXIS_MON_PROTOCOL_CHECK_EN
  localparam logic PCHK = 1'b1;
`else
  localparam logic PCHK = 1'b0;
`endif

  axis_stream_monitor dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .TVALID(TVALID), .TREADY(TREADY), .TDATA(TDATA),
    .TSTRB(TSTRB), .TKEEP(TKEEP), .TLAST(TLAST), .TID(TID), .TDEST(TDEST), .TUSER(TUSER),
    .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_tdata(cap_tdata),
    .cap_tstrb(cap_tstrb), .cap_tkeep(cap_tkeep), .cap_tlast(cap_tlast),
    .cap_tid(cap_tid), .cap_tdest(cap_tdest), .cap_tuser(cap_tuser),
    .pkt_done(pkt_done), .pkt_beats(pkt_beats), .pkt_bytes(pkt_bytes),
    .drop_cnt(drop_cnt), .err_id_change(err_id_change), .err_unstable(err_unstable),
    .err_valid_drop(err_valid_drop), .clear(clear)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k,
                       input logic l, input logic [3:0] id);
    TVALID = v; TDATA = d; TKEEP = k; TSTRB = k; TLAST = l; TID = id;
  endtask

  initial begin
    ARESETn = 1'b0; TVALID = 0; TREADY = 1; TDATA = 0; TSTRB = 0; TKEEP = 0;
    TLAST = 0; TID = 0; TDEST = 4'h2; TUSER = 0; cap_ready = 1; clear = 0;
    tick(); tick();
    check("rst_cap_valid", 64'(cap_valid), 64'd0);
    check("rst_pkt_done", 64'(pkt_done), 64'd0);
    check("rst_pkt_beats", 64'(pkt_beats), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_errs", 64'({err_id_change, err_unstable, err_valid_drop}), 64'd0);
    check("rst_cap_tdata", 64'(cap_tdata), 64'd0);
    ARESETn = 1'b1;
    tick();

    // 4-beat packet, bytes 4+4+4+2 = 14
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1000 + 32'(i), (i == 3) ? 4'h3 : 4'hF, i == 3, 4'h1);
      tick();
      check("p4_cap_valid", 64'(cap_valid), 64'd1);
      check("p4_cap_tdata", 64'(cap_tdata), 64'h1000 + 64'(i));
      check("p4_cap_tlast", 64'(cap_tlast), 64'(i == 3));
      check("p4_pkt_done_early", 64'(pkt_done), 64'(i == 3));
    end
    check("p4_cap_tkeep", 64'(cap_tkeep), 64'h3);
    check("p4_pkt_beats", 64'(pkt_beats), 64'd4);
    check("p4_pkt_bytes", 64'(pkt_bytes), 64'd14);
    drive(1'b0, 32'h0, 4'hF, 1'b0, 4'h1);
    tick();
    check("p4_done_pulse_end", 64'(pkt_done), 64'd0);
    check("p4_drained", 64'(cap_valid), 64'd0);
    check("p4_beats_hold", 64'(pkt_beats), 64'd4);

    // overflow: 10 beats into 8 entries, consumer stalled
    cap_ready = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h2000 + 32'(i), 4'hF, i == 9, 4'h1);
      tick();
    end
    drive(1'b0, 32'h0, 4'hF, 1'b0, 4'h1);
    check("ovf_cap_valid", 64'(cap_valid), 64'd1);
    check("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    check("ovf_pkt_beats", 64'(pkt_beats), 64'd10);
    check("ovf_pkt_bytes", 64'(pkt_bytes), 64'd40);
    tick();
    check("ovf_hold_head", 64'(cap_tdata), 64'h2000);
    cap_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain_valid", 64'(cap_valid), 64'd1);
      check("ovf_drain_data", 64'(cap_tdata), 64'h2000 + 64'(i));
      tick();
    end
    check("ovf_drain_empty", 64'(cap_valid), 64'd0);

    // full FIFO with simultaneous pop and beat
    cap_ready = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h3000 + 32'(i), 4'hF, 1'b1, 4'h1);
      tick();
    end
    check("full_no_drop", 64'(drop_cnt), 64'd2);
    drive(1'b1, 32'h3008, 4'hF, 1'b1, 4'h1);
    cap_ready = 1;
    tick();
    drive(1'b0, 32'h0, 4'hF, 1'b0, 4'h1);
    check("full_pop_push_drop", 64'(drop_cnt), 64'd2);
    for (int i = 1; i <= 8; i++) begin
      check("full_order_valid", 64'(cap_valid), 64'd1);
      check("full_order_data", 64'(cap_tdata), 64'h3000 + 64'(i));
      tick();
    end
    check("full_order_empty", 64'(cap_valid), 64'd0);

    // TID change mid-packet
    drive(1'b1, 32'h40, 4'hF, 1'b0, 4'h3); tick();
    drive(1'b1, 32'h41, 4'hF, 1'b0, 4'h3); tick();
    check("id_before", 64'(err_id_change), 64'd0);
    drive(1'b1, 32'h42, 4'hF, 1'b1, 4'h5); tick();
    check("id_set", 64'(err_id_change), 64'd1);
    drive(1'b0, 32'h0, 4'hF, 1'b0, 4'h5); tick();
    check("id_sticky", 64'(err_id_change), 64'd1);
    clear = 1; tick(); clear = 0;
    check("id_clear", 64'(err_id_change), 64'd0);
    check("drop_clear", 64'(drop_cnt), 64'd0);

    // payload change while stalled
    TREADY = 0;
    drive(1'b1, 32'hA5, 4'hF, 1'b0, 4'h1); tick();
    drive(1'b1, 32'h5A, 4'hF, 1'b0, 4'h1); tick();
    check("unstable", 64'(err_unstable), 64'(PCHK));
    check("unstable_no_vdrop", 64'(err_valid_drop), 64'd0);
    check("stall_no_push", 64'(cap_valid), 64'd0);
    TREADY = 1; drive(1'b0, 32'h5A, 4'hF, 1'b0, 4'h1);
    clear = 1; tick(); clear = 0;
    tick();
    check("unstable_clear", 64'(err_unstable), 64'd0);
    check("vdrop_clear_prio", 64'(err_valid_drop), 64'd0);

    // TVALID dropped while stalled, payload held
    TREADY = 0;
    drive(1'b1, 32'h77, 4'hF, 1'b0, 4'h1); tick();
    drive(1'b0, 32'h77, 4'hF, 1'b0, 4'h1); tick();
    check("valid_drop", 64'(err_valid_drop), 64'(PCHK));
    check("valid_drop_stable", 64'(err_unstable), 64'd0);
    TREADY = 1;
    clear = 1; tick(); clear = 0;

    // reset mid-packet with 3 entries queued
    cap_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h500 + 32'(i), 4'hF, 1'b0, 4'h1);
      tick();
    end
    drive(1'b0, 32'h0, 4'hF, 1'b0, 4'h1);
    check("mid_cap_valid", 64'(cap_valid), 64'd1);
    #2;
    ARESETn = 1'b0;
    #1;
    check("async_rst_cap_valid", 64'(cap_valid), 64'd0);
    check("async_rst_beats", 64'(pkt_beats), 64'd0);
    #1;
    ARESETn = 1'b1;
    cap_ready = 1;
    tick();
    drive(1'b1, 32'h600, 4'hF, 1'b1, 4'h1); tick();
    drive(1'b0, 32'h0, 4'hF, 1'b0, 4'h1);
    check("post_rst_done", 64'(pkt_done), 64'd1);
    check("post_rst_beats", 64'(pkt_beats), 64'd1);
    check("post_rst_bytes", 64'(pkt_bytes), 64'd4);
    check("post_rst_data", 64'(cap_tdata), 64'h600);
    tick();
    check("post_rst_empty", 64'(cap_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
